// File: rtl/boxcar_dec_if.sv
// Sample-in / decimated-sum-out bundle for boxcar_dec.
// The DUT takes the slave modport; the upstream/downstream side takes master.
interface boxcar_dec_if #(
  parameter int n = 16,
  parameter int r = 64
);
  localparam int m = n + $clog2(r);

  logic signed [n-1:0] in;
  logic                in_v;
  logic signed [m-1:0] out;
  logic                out_v;
  logic                out_r;
  logic                ovf;

  modport master (output in, in_v, out_r, input out, out_v, ovf);
  modport slave  (input in, in_v, out_r, output out, out_v, ovf);
endinterface

// File: rtl/boxcar_dec.sv
// Integrate-and-dump decimator: sums r valid samples at full precision and
// hands each sum to a one-entry valid/ready holding register with sticky ovf.
module boxcar_dec #(
  parameter int n = 16,
  parameter int r = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  boxcar_dec_if.slave  bus
);
  localparam int m  = n + $clog2(r);
  localparam int cw = $clog2(r);
  localparam logic [cw-1:0] CNT_LAST = cw'(r - 1);

  logic signed [m-1:0]  acc_q, acc_d;
  logic [cw-1:0]        cnt_q, cnt_d;
  logic signed [m-1:0]  out_q, out_d;
  logic                 out_v_q, out_v_d;
  logic                 ovf_q, ovf_d;

  logic signed [m-1:0]  sum;
  logic                 dump;
  logic                 hold_free;

  // m > n always holds since r >= 2, so the replication is never empty.
  assign sum       = acc_q + {{(m-n){bus.in[n-1]}}, bus.in};
  assign dump      = bus.in_v && (cnt_q == CNT_LAST);
  assign hold_free = !out_v_q || bus.out_r;

  always_comb begin
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    out_v_d = out_v_q;
    ovf_d   = ovf_q;

    if (bus.in_v) begin
      if (dump) begin
        acc_d = '0;
        cnt_d = '0;
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + 1'b1;
      end
    end

    // A dump takes priority over a plain consume; a consume in the same cycle frees the slot.
    if (dump) begin
      if (hold_free) begin
        out_d   = sum;
        out_v_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (out_v_q && bus.out_r) begin
      out_v_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      out_v_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      out_v_q <= out_v_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.out   = out_q;
  assign bus.out_v = out_v_q;
  assign bus.ovf   = ovf_q;
endmodule

// File: doc/boxcar_dec.md
Name: boxcar_dec

Overview:
- First-order integrate-and-dump (boxcar) decimator for the signed sample stream from the 1-bit DDC stage.
- Sums exactly r valid input samples, then emits one signed sum at full precision.
- Sits directly downstream of the bitstream-to-signed converter, feeding later filter/decimation stages.
- Output uses a valid/ready handshake with a one-entry holding register and a sticky overflow (dropped-result) flag.

Parameters:
n, 16, input sample width in bits, signed; must be >1.
r, 64, decimation ratio (input samples per output); must be >=2; need not be a power of two.
m, n+$clog2(r), output width in bits, signed; derived; must not be overridden.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst_n  input  1  reset, synchronous, active-low.
in  input  n  signed input sample.
in_v  input  1  in is valid this cycle; no input-side backpressure; every in_v cycle is consumed.
out  output  m  signed decimated sum; stable while out_v=1.
out_v  output  1  out holds an unconsumed result.
out_r  input  1  downstream accepts out when out_v=1 and out_r=1.
ovf  output  1  sticky; a result was discarded because the holding register was full.

Behaviour:
- Reset (rst_n=0 at a rising clk edge) clears all state:
  - acc=0, cnt=0, out=0, out_v=0, ovf=0.
  - Any partial sum is discarded.
  - The next block starts fresh after rst_n returns to 1.
- Internal state:
  - acc: signed, m bits.
  - cnt: counts 0..r-1, $clog2(r) bits.
- Cycles with in_v=0 leave acc and cnt unchanged.
- Accumulate cycle: in_v=1 and cnt<r-1:
  - acc <= acc + sign_extend(in).
  - cnt <= cnt+1.
- Dump cycle: in_v=1 and cnt==r-1:
  - sum = acc + sign_extend(in).
  - acc <= 0, cnt <= 0.
  - The result is offered to the holding register.
- Holding register load:
  - The register is free if out_v==0, or if out_v==1 and out_r==1 in the same cycle (consume and reload at once).
  - If free: out <= sum, out_v <= 1.
  - If not free (out_v=1 and out_r=0): sum is discarded; out and out_v are unchanged; ovf <= 1.
  - ovf stays 1 until reset.
- Consume: out_v=1, out_r=1 and no load in that cycle gives out_v <= 0. out keeps its last value.
- Latency: the result appears on out/out_v on the clock edge that completes the dump cycle, i.e. visible the cycle after the r-th valid sample is presented.
- Throughput: one output per r valid inputs. With r>=2, out_r held high never loses data.
- Width rule: m=n+$clog2(r) guarantees no wrap for any r samples of n-bit signed input.
  - Worst case is r*(-2^(n-1)).
  - No saturation logic is required or allowed.
- out_r is ignored while out_v=0.
- Simultaneous events:
  - A dump plus consume in the same cycle loads the new result; out_v stays 1.
  - A dump plus reset: reset wins.

Test Plan (n=16, r=4, m=18):
1. Reset, then 4 cycles in=32767, in_v=1, out_r=1 -> one cycle after the 4th sample, out_v=1 and out=131068; out_v drops the next cycle; ovf=0.
2. 4 samples of -32768 -> out=-131072 (18-bit minimum, no wrap). Then alternating 32767/-32768 for 4 samples -> out=-2.
3. in_v toggled 1,0,0,1,1,0,1 with in=1 on each valid -> exactly one output, out=4, appearing after the 4th valid sample; the gaps do not advance cnt.
4. out_r=0; feed 8 samples of in=1 -> first result out=4 is held with out_v=1; the second result is discarded and ovf=1. Raise out_r -> out_v clears; ovf stays 1 until rst_n=0.
5. out_v=1 with out=4 pending. Present the 4th sample of the next block (in=2, running sum 8) together with out_r=1 -> out becomes 8 and out_v stays 1 continuously; ovf=0.
6. Feed 2 samples of in=100, pulse rst_n=0 for one cycle, then 4 samples of in=1 -> out=4 (partial sum discarded); out_v, out and ovf read 0 during and right after reset.
